// File: rtl/cpu_imm_pkg.sv
// rtl/cpu_imm_pkg.sv - shared types and constants for the immediate-operand sequencer
// Purpose : operand mode and sequencer state enums, datapath widths, mode legality helper.
// Ports   : none (package).
// Macro   : IMM_LUI_EN makes mode 2'b11 (LUI8) legal; undefined it is rejected with imm_err.
package cpu_imm_pkg;

  localparam int IMM_W  = 16;
  localparam int BYTE_W = 8;

`ifdef IMM_LUI_EN
  localparam bit LUI_EN = 1'b1;
`else
  localparam bit LUI_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    SEXT8 = 2'b00,
    ZEXT8 = 2'b01,
    IMM16 = 2'b10,
    LUI8  = 2'b11
  } imm_mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BYTE0 = 2'b01,
    S_BYTE1 = 2'b10,
    S_OUT   = 2'b11
  } seq_state_t;

  function automatic logic mode_is_legal(input imm_mode_t m);
    return (m != LUI8) || LUI_EN;
  endfunction

endpackage

// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - combinational 8->16 extension / 16-bit assembly of immediate bytes
// Purpose : turns the operand mode and up to two instruction bytes into the 16-bit immediate.
// Ports   : i_mode   operand mode
//           i_b0     first instruction byte
//           i_b1     second instruction byte (IMM16 only)
//           o_result 16-bit immediate
// Macro   : IMM_LUI_EN adds the LUI8 case; otherwise mode 2'b11 yields zero.
module imm_extend_unit
  import cpu_imm_pkg::*;
#(
  parameter int LITTLE_END = 1
) (
  input  imm_mode_t          i_mode,
  input  logic [BYTE_W-1:0]  i_b0,
  input  logic [BYTE_W-1:0]  i_b1,
  output logic [IMM_W-1:0]   o_result
);

  always_comb begin
    o_result = '0;
    case (i_mode)
      SEXT8:   o_result = {{BYTE_W{i_b0[BYTE_W-1]}}, i_b0};
      ZEXT8:   o_result = {{BYTE_W{1'b0}}, i_b0};
      IMM16:   o_result = (LITTLE_END != 0) ? {i_b1, i_b0} : {i_b0, i_b1};
`ifdef IMM_LUI_EN
      LUI8:    o_result = {i_b0, {BYTE_W{1'b0}}};
`endif
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/imm_operand_sequencer.sv
// rtl/imm_operand_sequencer.sv - immediate-operand fetch sequencer for the decode stage
// Purpose : accepts one operand request, pulls 1 or 2 bytes from the instruction byte
//           stream and presents one registered 16-bit immediate to the operand mux.
// Ports   : clk, rst_n                         clock / async active-low reset
//           req_valid, req_ready, req_mode     operand request handshake
//           byte_valid, byte_ready, byte_data  instruction byte stream
//           imm_valid, imm_ready, imm_data     immediate result handshake
//           imm_err                            result is an abort (illegal mode / timeout)
//           busy                               sequencer not idle
// Macro   : IMM_LUI_EN enables mode 2'b11 (LUI8); undefined it is an illegal mode.
module imm_operand_sequencer
  import cpu_imm_pkg::*;
#(
  parameter int LITTLE_END  = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_mode,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              imm_valid,
  input  logic              imm_ready,
  output logic [IMM_W-1:0]  imm_data,
  output logic              imm_err,
  output logic              busy
);

  // Counter only needs to reach TIMEOUT_CYC-1: the final stall cycle triggers the abort.
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  seq_state_t         r_state;
  imm_mode_t          r_mode;
  logic [BYTE_W-1:0]  r_b0;
  logic [WD_W-1:0]    r_wd;
  logic               r_req_ready;
  logic               r_byte_ready;
  logic               r_imm_valid;
  logic [IMM_W-1:0]   r_imm_data;
  logic               r_imm_err;
  logic               r_busy;

  imm_mode_t          w_req_mode;
  logic [BYTE_W-1:0]  w_b0;
  logic [IMM_W-1:0]   w_ext;
  logic               w_timeout;

  assign w_req_mode = imm_mode_t'(req_mode);
  // In BYTE0 the byte on the bus is b0 itself; in BYTE1 it is b1 and b0 is already captured.
  assign w_b0       = (r_state == S_BYTE0) ? byte_data : r_b0;
  assign w_timeout  = (TIMEOUT_CYC != 0) && (r_wd == WD_W'(TIMEOUT_CYC - 1));

  imm_extend_unit #(
    .LITTLE_END (LITTLE_END)
  ) u_extend (
    .i_mode   (r_mode),
    .i_b0     (w_b0),
    .i_b1     (byte_data),
    .o_result (w_ext)
  );

  // Handshake outputs are registered alongside the state so they follow it exactly;
  // req_ready stays low during reset and rises on the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= SEXT8;
      r_b0         <= '0;
      r_wd         <= '0;
      r_req_ready  <= 1'b0;
      r_byte_ready <= 1'b0;
      r_imm_valid  <= 1'b0;
      r_imm_data   <= '0;
      r_imm_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_mode      <= w_req_mode;
            r_b0        <= '0;
            r_wd        <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (mode_is_legal(w_req_mode)) begin
              r_state      <= S_BYTE0;
              r_byte_ready <= 1'b1;
            end else begin
              r_state     <= S_OUT;
              r_imm_valid <= 1'b1;
              r_imm_data  <= '0;
              r_imm_err   <= 1'b1;
            end
          end
        end
        S_BYTE0, S_BYTE1: begin
          if (byte_valid) begin
            r_wd <= '0;
            if (r_state == S_BYTE0) begin
              r_b0 <= byte_data;
            end
            if ((r_state == S_BYTE0) && (r_mode == IMM16)) begin
              r_state <= S_BYTE1;
            end else begin
              r_state      <= S_OUT;
              r_byte_ready <= 1'b0;
              r_imm_valid  <= 1'b1;
              r_imm_data   <= w_ext;
              r_imm_err    <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state      <= S_OUT;
            r_byte_ready <= 1'b0;
            r_imm_valid  <= 1'b1;
            r_imm_data   <= '0;
            r_imm_err    <= 1'b1;
            r_b0         <= '0;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        S_OUT: begin
          if (imm_ready) begin
            r_state     <= S_IDLE;
            r_imm_valid <= 1'b0;
            r_imm_data  <= '0;
            r_imm_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b0;
          r_imm_valid  <= 1'b0;
          r_req_ready  <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign byte_ready = r_byte_ready;
  assign imm_valid  = r_imm_valid;
  assign imm_data   = r_imm_data;
  assign imm_err    = r_imm_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_imm_operand_sequencer.sv
// tb/tb_imm_operand_sequencer.sv - directed self-checking bench for imm_operand_sequencer
module tb_imm_operand_sequencer;

  localparam int LE = 1;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_mode = 2'b00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [7:0]  byte_data = 8'h00;
  logic        imm_valid;
  logic        imm_ready = 1'b0;
  logic [15:0] imm_data;
  logic        imm_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  int nbytes = 0;
  int nres = 0;
  logic [16:0] exp_q[$];

  imm_operand_sequencer #(.LITTLE_END(LE), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .imm_valid(imm_valid), .imm_ready(imm_ready), .imm_data(imm_data),
    .imm_err(imm_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected {err, data} from the operand rules, using plain arithmetic.
  function automatic logic [16:0] model(input int mode, input int b0, input int b1);
    int v;
    case (mode)
      0: v = (b0 >= 128) ? b0 + 65280 : b0;
      1: v = b0;
      2: v = (LE != 0) ? b1 * 256 + b0 : b0 * 256 + b1;
      default: begin
`ifdef IMM_LUI_EN
        v = b0 * 256;
`else
        return 17'h10000;
`endif
      end
    endcase
    return {1'b0, v[15:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid && byte_ready) nbytes++;
      if (imm_valid) begin
        chk("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("result_value", {imm_err, imm_data}, exp_q[0]);
          if (imm_ready) begin
            void'(exp_q.pop_front());
            nres++;
          end
        end
      end
      chk("ready_overlap", byte_ready && (imm_valid || req_ready), 0);
    end
  end

  task automatic send_req(input logic [1:0] m);
    int n = 0;
    req_mode = m;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_accept", req_ready, 1);
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_data = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && n < 100) begin @(negedge clk); n++; end
    chk("byte_accept", byte_ready, 1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, output int vcyc, output logic [15:0] d, output logic e);
    int n = 0;
    @(negedge clk);
    while (!imm_valid && n < 50) begin @(negedge clk); n++; end
    chk("result_arrives", imm_valid, 1);
    vcyc = cyc;
    d = imm_data;
    e = imm_err;
    if (imm_valid) begin
      if (!imm_ready) begin
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          chk("hold_valid", imm_valid, 1);
          chk("hold_data", {imm_err, imm_data}, {e, d});
        end
        @(posedge clk); #1 imm_ready = 1'b1;
        @(posedge clk); #1 imm_ready = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int vc;
    int nb0;
    logic [15:0] d;
    logic e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_imm_valid", imm_valid, 0);
    chk("rst_imm_data", imm_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", req_ready, 1);

    // SEXT8 0xAA with consumer ready
    imm_ready = 1'b1;
    exp_q.push_back(model(0, 8'hAA, 0));
    fork send_req(2'b00); send_byte(8'hAA, 0); join
    wait_result(0, vc, d, e);
    chk("sext8_latency", vc - acc, 1);
    chk("sext8_data", d, 16'hFFAA);
    chk("sext8_err", e, 0);

    // ZEXT8 then IMM16 back to back
    exp_q.push_back(model(1, 8'h80, 0));
    fork send_req(2'b01); send_byte(8'h80, 0); join
    wait_result(0, vc, d, e);
    chk("zext8_data", d, 16'h0080);
    exp_q.push_back(model(2, 8'h34, 8'h12));
    fork send_req(2'b10); begin send_byte(8'h34, 0); send_byte(8'h12, 0); end join
    wait_result(0, vc, d, e);
    chk("imm16_latency", vc - acc, 2);
    chk("imm16_data", d, 16'h1234);

    // IMM16 with gapped bytes and stalled consumer
    imm_ready = 1'b0;
    nb0 = nres;
    exp_q.push_back(model(2, 8'hCD, 8'hAB));
    fork send_req(2'b10); begin send_byte(8'hCD, 0); send_byte(8'hAB, 3); end join
    wait_result(5, vc, d, e);
    chk("gap_data", d, 16'hABCD);
    chk("gap_one_result", nres - nb0, 1);

    // Watchdog: IMM16 with only one byte
    imm_ready = 1'b1;
    nb0 = nbytes;
    exp_q.push_back(17'h10000);
    fork send_req(2'b10); send_byte(8'h77, 0); join
    wait_result(0, vc, d, e);
    chk("timeout_latency", vc - acc, TO + 1);
    chk("timeout_err", e, 1);
    chk("timeout_data", d, 0);
    chk("timeout_bytes", nbytes - nb0, 1);
    exp_q.push_back(model(0, 8'h7F, 0));
    fork send_req(2'b00); send_byte(8'h7F, 0); join
    wait_result(0, vc, d, e);
    chk("after_timeout_data", d, 16'h007F);

    // Mode 11 with byte 0x5C on the bus
    nb0 = nbytes;
    exp_q.push_back(model(3, 8'h5C, 0));
    byte_data = 8'h5C;
    byte_valid = 1'b1;
    send_req(2'b11);
    wait_result(0, vc, d, e);
`ifdef IMM_LUI_EN
    chk("lui_latency", vc - acc, 1);
    chk("lui_data", {e, d}, 17'h05C00);
    chk("lui_bytes", nbytes - nb0, 1);
`else
    chk("illegal_latency", vc - acc, 0);
    chk("illegal_result", {e, d}, 17'h10000);
    chk("illegal_bytes", nbytes - nb0, 0);
`endif
    byte_valid = 1'b0;

    // Asynchronous reset while waiting for the second IMM16 byte
    exp_q.push_back(model(2, 8'h11, 8'h22));
    fork send_req(2'b10); send_byte(8'h11, 0); join
    chk("byte1_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 0);
    chk("arst_byte_ready", byte_ready, 0);
    chk("arst_imm_valid", imm_valid, 0);
    chk("arst_imm_data", imm_data, 0);
    chk("arst_imm_err", imm_err, 0);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_release_req_ready", req_ready, 1);
    chk("arst_release_busy", busy, 0);
    exp_q.push_back(model(0, 8'h80, 0));
    fork send_req(2'b00); send_byte(8'h80, 0); join
    wait_result(0, vc, d, e);
    chk("after_reset_data", d, 16'hFF80);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("result_count", nres, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
